fetch_stage_ctrl: RTL and testbench

//   IF-stage front end of the 5-stage RV32I pipeline: owns the PC register, issues instruction

---
 rtl/fetch_stage_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_stage_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// ============================================================================
// fetch_stage_ctrl : RV32I IF-stage PC, fetch issue, IF/ID register, one-entry skid
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_ready_i,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      if_id_pc_q;
    logic [31:0]      if_id_instr_q;
    logic             if_id_valid_q;
    logic [31:0]      skid_pc_q;
    logic [31:0]      skid_instr_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [31:0]      pc_plus4_d;

    assign pc_plus4_d = pc_q + 32'd4;

    assign stall_cnt_d = (stall_i && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}
                       : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'd0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            skid_pc_q     <= 32'd0;
            skid_instr_q  <= 32'd0;
            stall_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (branch_taken_i) begin
                // Redirect wins over everything; the in-flight fetch and any skid are dropped.
                pc_q          <= branch_target_i & ~32'd3;
                if_id_instr_q <= NOP_INSTR;
                if_id_valid_q <= 1'b0;
                skid_pc_q     <= 32'd0;
                skid_instr_q  <= 32'd0;
                state_q       <= S_FETCH;
            end else begin
                case (state_q)
                    S_BOOT: begin
                        state_q <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (imem_ready_i && !stall_i) begin
                            if_id_pc_q    <= pc_q;
                            if_id_instr_q <= imem_rdata_i;
                            if_id_valid_q <= 1'b1;
                            pc_q          <= pc_plus4_d;
                        end else if (imem_ready_i && stall_i) begin
                            skid_pc_q    <= pc_q;
                            skid_instr_q <= imem_rdata_i;
                            state_q      <= S_HELD;
                        end else if (!stall_i) begin
                            if_id_instr_q <= NOP_INSTR;
                            if_id_valid_q <= 1'b0;
                        end
                    end
                    S_HELD: begin
                        if (!stall_i) begin
                            if_id_pc_q    <= skid_pc_q;
                            if_id_instr_q <= skid_instr_q;
                            if_id_valid_q <= 1'b1;
                            pc_q          <= pc_plus4_d;
                            state_q       <= S_FETCH;
                        end
                    end
                    default: begin
                        state_q <= S_BOOT;
                    end
                endcase
            end
        end
    end

    assign imem_req_o    = (state_q == S_FETCH);
    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc4_o   = if_id_pc_q + 32'd4;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
// ============================================================================
// tb_fetch_stage_ctrl : directed self-checking bench for fetch_stage_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage_ctrl;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_tgt = 32'd0;
    logic [31:0] rdata;
    logic        ready = 1'b0;

    logic        req, req_s;
    logic [31:0] addr, addr_s;
    logic [31:0] pc, pc_s, pc4, pc4_s, instr, instr_s;
    logic        valid, valid_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : (32'hABC0_0000 | a);
    endfunction

    assign rdata = mem(addr);

    fetch_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br),
        .branch_target_i(br_tgt), .imem_req_o(req), .imem_addr_o(addr),
        .imem_rdata_i(rdata), .imem_ready_i(ready), .if_id_pc_o(pc),
        .if_id_pc4_o(pc4), .if_id_instr_o(instr), .if_id_valid_o(valid),
        .stall_cnt_o(cnt)
    );

    fetch_stage_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br),
        .branch_target_i(br_tgt), .imem_req_o(req_s), .imem_addr_o(addr_s),
        .imem_rdata_i(rdata), .imem_ready_i(ready), .if_id_pc_o(pc_s),
        .if_id_pc4_o(pc4_s), .if_id_instr_o(instr_s), .if_id_valid_o(valid_s),
        .stall_cnt_o(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ifid(input string tag, input logic [31:0] epc, input logic [31:0] ein,
                        input logic ev);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".instr"}, instr, ein);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    initial begin
        // Reset and release on a falling edge; DUT sits in BOOT.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        chk("rst.req", {31'd0, req}, 32'd0);
        chk("rst.addr", addr, 32'd0);
        ifid("rst", 32'd0, c_NOP, 1'b0);
        chk("rst.pc4", pc4, 32'd4);
        chk("rst.cnt", {16'd0, cnt}, 32'd0);

        // 1: BOOT for one cycle, then back-to-back fetches
        step();
        chk("t1.req", {31'd0, req}, 32'd1);
        chk("t1.addr", addr, 32'd0);
        chk("t1.valid0", {31'd0, valid}, 32'd0);
        step(); ifid("t1.i0", 32'h0, mem(32'h0), 1'b1);
        step(); ifid("t1.i1", 32'h4, mem(32'h4), 1'b1);
        step(); ifid("t1.i2", 32'h8, mem(32'h8), 1'b1);
        step(); ifid("t1.i3", 32'hC, mem(32'hC), 1'b1);
        chk("t1.addr10", addr, 32'h10);

        // 2: stall while fetch completes at 0x10, three cycles
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t2.req", {31'd0, req}, 32'd0);
            ifid("t2.hold", 32'hC, mem(32'hC), 1'b1);
            chk("t2.cnt", {16'd0, cnt}, i);
        end
        stall = 1'b0;
        step();
        ifid("t2.skid", 32'h10, 32'h0050_0093, 1'b1);
        chk("t2.addr", addr, 32'h14);
        chk("t2.req1", {31'd0, req}, 32'd1);
        chk("t2.cnt3", {16'd0, cnt}, 32'd3);

        // 3: enter HELD, then branch while still stalled
        stall = 1'b1;
        step();
        chk("t3.req", {31'd0, req}, 32'd0);
        br = 1'b1;
        br_tgt = 32'h203;
        step();
        br = 1'b0;
        stall = 1'b0;
        chk("t3.addr", addr, 32'h200);
        chk("t3.req", {31'd0, req}, 32'd1);
        ifid("t3.bub", 32'h10, c_NOP, 1'b0);
        chk("t3.cnt", {16'd0, cnt}, 32'd5);
        step();
        ifid("t3.new", 32'h200, mem(32'h200), 1'b1);
        chk("t3.addr2", addr, 32'h204);

        // 4: two cycles of memory wait produce bubbles; PC advances once afterwards
        ready = 1'b0;
        step(); ifid("t4.b0", 32'h200, c_NOP, 1'b0);
        chk("t4.addr0", addr, 32'h204);
        step(); ifid("t4.b1", 32'h200, c_NOP, 1'b0);
        chk("t4.addr1", addr, 32'h204);
        ready = 1'b1;
        step(); ifid("t4.real", 32'h204, mem(32'h204), 1'b1);
        chk("t4.addr2", addr, 32'h208);

        // 5: redirect to the top of the address space and wrap
        br = 1'b1;
        br_tgt = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        chk("t5.addr", addr, 32'hFFFF_FFFC);
        chk("t5.valid", {31'd0, valid}, 32'd0);
        step();
        ifid("t5.top", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1);
        chk("t5.pc4", pc4, 32'd0);
        chk("t5.addr0", addr, 32'd0);

        // 6: fresh reset, long stall saturates the narrow counter, then async reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t6.cnt2", {30'd0, cnt_s}, (i > 3) ? 32'd3 : i);
            chk("t6.cnt16", {16'd0, cnt}, i);
        end
        chk("t6.req_held", {31'd0, req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst.cnt2", {30'd0, cnt_s}, 32'd0);
        chk("t6.rst.cnt16", {16'd0, cnt}, 32'd0);
        chk("t6.rst.req", {31'd0, req}, 32'd0);
        chk("t6.rst.addr", addr, 32'd0);
        ifid("t6.rst", 32'd0, c_NOP, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        ifid("t6.after", 32'h0, mem(32'h0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
